// File: rtl/gate_pkg.sv
// Shared definitions for the bit-serial gate blocks.
// Contents:
//   gate_op_t  - per-beat gate select encoding (AND, OR, XOR, NAND)
//   GATE_OP_W  - width of the gate select field
package gate_pkg;

  localparam int GATE_OP_W = 2;

  typedef enum logic [GATE_OP_W-1:0] {
    GATE_AND  = 2'b00,
    GATE_OR   = 2'b01,
    GATE_XOR  = 2'b10,
    GATE_NAND = 2'b11
  } gate_op_t;

endpackage

// File: rtl/gate_unit_using_mux.sv
// Combinational two-input gate built only from 2:1 multiplexers.
// Ports:
//   a, b  input  operands
//   op    input  gate select (gate_op_t encoding)
//   y     output gate result

// Basic 2:1 mux: y = sel ? d1 : d0
module mux2 (
  input  logic sel,
  input  logic d0,
  input  logic d1,
  output logic y
);
  assign y = sel ? d1 : d0;
endmodule

module gate_unit_using_mux
  import gate_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  input  logic [GATE_OP_W-1:0] op,
  output logic                 y
);

  logic nb;
  logic and_y, or_y, xor_y, nand_y;
  logic lo_y, hi_y;

  // Operand a steers each gate: a=0 picks the a=0 column of the truth
  // table, a=1 picks the a=1 column expressed in terms of b.
  mux2 u_not_b (.sel(b), .d0(1'b1), .d1(1'b0), .y(nb));
  mux2 u_and   (.sel(a), .d0(1'b0), .d1(b),    .y(and_y));
  mux2 u_or    (.sel(a), .d0(b),    .d1(1'b1), .y(or_y));
  mux2 u_xor   (.sel(a), .d0(b),    .d1(nb),   .y(xor_y));
  mux2 u_nand  (.sel(a), .d0(1'b1), .d1(nb),   .y(nand_y));

  // Two-level select tree over the op code.
  mux2 u_sel_lo (.sel(op[0]), .d0(and_y), .d1(or_y),   .y(lo_y));
  mux2 u_sel_hi (.sel(op[0]), .d0(xor_y), .d1(nand_y), .y(hi_y));
  mux2 u_sel    (.sel(op[1]), .d0(lo_y),  .d1(hi_y),   .y(y));

endmodule

// File: rtl/serial_gate_deserializer.sv
// Bit-serial gate evaluation with LSB-first packing into WIDTH-bit words.
// Each accepted beat evaluates gate(in_op, in_a, in_b) and writes the result
// into the next bit of the word under assembly. A word completes when its
// last bit is filled or in_last is seen, and is then presented on a
// registered valid/ready output.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream beat handshake (in_ready is combinational)
//   in_a, in_b, in_op   operands and gate select for the beat
//   in_last             beat closes the current word early
//   out_valid/out_ready downstream word handshake
//   out_data            packed result bits, unfilled bits zero
//   out_count           number of valid bits in out_data (1..WIDTH)
module serial_gate_deserializer
  import gate_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_a,
  input  logic                 in_b,
  input  logic [GATE_OP_W-1:0] in_op,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CW-1:0]        out_count
);

  localparam logic [0:0]    COLLECT  = 1'b0;
  localparam logic [0:0]    HOLD     = 1'b1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic [0:0]       state_q;
  logic [WIDTH-1:0] asm_q;
  logic [CW-1:0]    cnt_q;
  logic             r;
  logic             accept;
  logic             complete;
  logic             pop;
  logic [WIDTH-1:0] word_next;

  gate_unit_using_mux u_gate (
    .a  (in_a),
    .b  (in_b),
    .op (in_op),
    .y  (r)
  );

  assign out_valid = (state_q == HOLD);
  assign in_ready  = !out_valid || out_ready;

  always_comb begin
    accept    = in_valid && in_ready;
    complete  = accept && ((cnt_q == LAST_IDX) || in_last);
    pop       = out_valid && out_ready;
    // Bits above cnt_q are always zero in asm_q, so OR-ing in the new bit
    // also yields the zero-padded output word on an early close.
    word_next = asm_q | (WIDTH'(r) << cnt_q);
  end

  // Assembly / output stage boundary: completion moves the word out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      asm_q     <= '0;
      cnt_q     <= '0;
      out_data  <= '0;
      out_count <= '0;
    end else begin
      if (accept) begin
        if (complete) begin
          out_data  <= word_next;
          out_count <= cnt_q + CW'(1);
          asm_q     <= '0;
          cnt_q     <= '0;
        end else begin
          asm_q <= word_next;
          cnt_q <= cnt_q + CW'(1);
        end
      end
      // A completing accept always (re)fills the output, even on a pop.
      if (complete)
        state_q <= HOLD;
      else if (pop)
        state_q <= COLLECT;
    end
  end

endmodule

// File: tb/tb_serial_gate_deserializer.sv
module tb_serial_gate_deserializer;
  import gate_pkg::*;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_a;
  logic             in_b;
  logic [1:0]       in_op;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_count;

  serial_gate_deserializer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       op;
    logic             a;
    logic             b;
    logic             last;
    logic             done;
    logic [WIDTH-1:0] data;
    logic [CW-1:0]    cnt;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [CW-1:0]    cnt;
  } word_t;

  vec_t  tbl[$];
  word_t sb[$];
  int    n_vec  = 0;
  int    n_err  = 0;
  int    stalls = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void addv(input gate_op_t op, input logic a, input logic b,
                               input logic last, input logic done,
                               input logic [WIDTH-1:0] data, input logic [CW-1:0] cnt);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.last = last;
    v.done = done; v.data = data; v.cnt = cnt;
    tbl.push_back(v);
  endfunction

  function automatic void push_word(input logic [WIDTH-1:0] data, input logic [CW-1:0] cnt);
    word_t w;
    w.data = data; w.cnt = cnt;
    sb.push_back(w);
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send_beat(input logic [1:0] op, input logic a, input logic b, input logic last);
    int t;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_last = last;
    t = 0;
    @(negedge clk);
    if (!in_ready) stalls++;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL beat_timeout in_ready=%0b required=1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_last = 1'b0; in_a = 1'b0; in_b = 1'b0; in_op = 2'b00;
  endtask

  // Scoreboard: every consumed word must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_word data=%0h count=%0d required=none", out_data, out_count);
      end else begin
        word_t e;
        e = sb.pop_front();
        check("word_data", 32'(out_data), 32'(e.data));
        check("word_count", 32'(out_count), 32'(e.cnt));
      end
    end
  end

  initial begin
    logic [7:0] bseq;
    int t;
    rst_n = 1'b0; out_ready = 1'b1;
    idle();

    // ---- reset state ----
    #12;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data",  32'(out_data),  0);
    check("rst_out_count", 32'(out_count), 0);
    check("rst_in_ready",  32'(in_ready),  1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- table-driven words, out_ready=1 throughout ----
    bseq = 8'b0100_1101;   // b sequence 1,0,1,1,0,0,1,0 from bit 0
    for (int i = 0; i < 8; i++)
      addv(GATE_AND, 1'b1, bseq[i], 1'b0, (i == 7), 8'h4D, 4'd8);
    addv(GATE_OR, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
    addv(GATE_OR, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0);
    addv(GATE_OR, 1'b0, 1'b0, 1'b1, 1'b1, 8'h03, 4'd3);
    for (int i = 0; i < 8; i++)
      addv(GATE_XOR, 1'b1, 1'b1, 1'b0, (i == 7), 8'h00, 4'd8);
    for (int i = 0; i < 8; i++)
      addv(GATE_NAND, 1'b0, 1'b0, 1'b0, (i == 7), 8'hFF, 4'd8);
    // mixed ops in one word: bits 1,0,1,0,0,1,0,1
    addv(GATE_AND,  1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
    addv(GATE_OR,   1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0);
    addv(GATE_XOR,  1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0);
    addv(GATE_NAND, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
    addv(GATE_AND,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
    addv(GATE_OR,   1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0);
    addv(GATE_XOR,  1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
    addv(GATE_NAND, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 4'd8);
    // in_last on the beat that also fills the top bit: one full word only
    for (int i = 0; i < 8; i++)
      addv(GATE_OR, 1'b1, 1'b0, (i == 7), (i == 7), 8'hFF, 4'd8);
    // in_last on the first beat
    addv(GATE_AND, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 4'd1);
    addv(GATE_AND, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 4'd1);

    stalls = 0;
    foreach (tbl[i]) begin
      if (tbl[i].done) push_word(tbl[i].data, tbl[i].cnt);
      send_beat(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].last);
    end
    idle();
    check("no_stall_streaming", 32'(stalls), 0);
    repeat (3) @(posedge clk);
    #1;

    // ---- backpressure: hold word, then pop and accept in the same cycle ----
    out_ready = 1'b0;
    push_word(8'h55, 4'd8);
    for (int i = 0; i < 8; i++)
      send_beat(GATE_XOR, 1'b1, i[0], 1'b0);
    push_word(8'h01, 4'd1);
    fork
      send_beat(GATE_AND, 1'b1, 1'b1, 1'b1);
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("hold_in_ready",  32'(in_ready),  0);
          check("hold_out_valid", 32'(out_valid), 1);
          check("hold_out_data",  32'(out_data),  32'h55);
          check("hold_out_count", 32'(out_count), 8);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        check("pop_in_ready", 32'(in_ready), 1);
      end
    join
    idle();
    repeat (3) @(posedge clk);
    #1;

    // ---- asynchronous reset while a word is held ----
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      send_beat(GATE_OR, 1'b1, 1'b0, 1'b0);
    idle();
    @(posedge clk); #2;
    check("prereset_out_valid", 32'(out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 0);
    check("async_rst_out_data",  32'(out_data),  0);
    check("async_rst_out_count", 32'(out_count), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;

    // ---- reset mid-word discards the partial word ----
    for (int i = 0; i < 4; i++)
      send_beat(GATE_AND, 1'b1, 1'b1, 1'b0);
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("midword_rst_out_valid", 32'(out_valid), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    push_word(8'h00, 4'd8);
    for (int i = 0; i < 8; i++)
      send_beat(GATE_AND, 1'b0, 1'b1, 1'b0);
    idle();

    // ---- drain ----
    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("scoreboard_drained", 32'(sb.size()), 0);
    repeat (2) @(posedge clk);
    #1;
    check("final_out_valid", 32'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
